// File: rtl/error_event_logger_if.sv
// Bus between the error event logger and its environment.
//   master : error source / software side (drives error, read-pop, clear, ack)
//   slave  : error_event_logger (drives log head, counters, escalation status)
// Signals:
//   error_valid_i, error_code_i  aggregated error stream (level-held)
//   rd_valid_o, rd_code_o, rd_ts_o, rd_ready_i  show-ahead log head and pop
//   clear_i  flush log / overflow status;  ack_i  acknowledge pending error
//   count_o, overflow_o, overflow_cnt_o  log occupancy and drop status
//   esc_state_o, fault_o  escalation FSM state and sticky fault
interface error_event_logger_if #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TS_W  = 32
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            error_valid_i;
    logic [31:0]     error_code_i;
    logic            rd_valid_o;
    logic [31:0]     rd_code_o;
    logic [TS_W-1:0] rd_ts_o;
    logic            rd_ready_i;
    logic            clear_i;
    logic            ack_i;
    logic [CntW-1:0] count_o;
    logic            overflow_o;
    logic [15:0]     overflow_cnt_o;
    logic [1:0]      esc_state_o;
    logic            fault_o;

    modport master (
        output error_valid_i, error_code_i, rd_ready_i, clear_i, ack_i,
        input  rd_valid_o, rd_code_o, rd_ts_o, count_o, overflow_o, overflow_cnt_o,
               esc_state_o, fault_o
    );

    modport slave (
        input  error_valid_i, error_code_i, rd_ready_i, clear_i, ack_i,
        output rd_valid_o, rd_code_o, rd_ts_o, count_o, overflow_o, overflow_cnt_o,
               esc_state_o, fault_o
    );
endinterface

// File: rtl/error_event_logger.sv
// Error event logger: turns the level-held aggregated error stream into discrete
// timestamped events, stores them in a circular show-ahead log, and escalates to a
// sticky fault when software does not acknowledge within ESC_TIMEOUT cycles.
// Ports:
//   clk_i    clock
//   rst_n_i  asynchronous active-low reset
//   bus      error_event_logger_if.slave (error input, log read side, clear/ack,
//            occupancy/overflow status, escalation state and fault)
module error_event_logger #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned TS_W        = 32,
    parameter int unsigned ESC_TIMEOUT = 1024
) (
    input logic                 clk_i,
    input logic                 rst_n_i,
    error_event_logger_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned TmrW = (ESC_TIMEOUT > 1) ? $clog2(ESC_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StPending   = 2'd1,
        StEscalated = 2'd2
    } esc_state_e;

    logic [TS_W-1:0] ts_q;
    logic            valid_q;
    logic [31:0]     code_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            overflow_q;
    logic [15:0]     ovf_cnt_q;
    esc_state_e      state_q;
    logic [TmrW-1:0] timer_q;
    logic            fault_q;

    logic [31:0]     mem_code [DEPTH];
    logic [TS_W-1:0] mem_ts   [DEPTH];

    logic evt;
    logic not_empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        evt       = bus.error_valid_i && (!valid_q || (bus.error_code_i != code_q));
        not_empty = (count_q != '0);
        full      = (count_q == CntW'(DEPTH));
        // clear wins over everything; a pop frees the slot a full-log push needs
        pop       = not_empty && bus.rd_ready_i && !bus.clear_i;
        push      = evt && !bus.clear_i && (!full || pop);
        drop      = evt && !bus.clear_i && full && !pop;
    end

    // Timestamp and previous-cycle error sample for edge/change detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ts_q    <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
        end else begin
            ts_q    <= ts_q + 1'b1;
            valid_q <= bus.error_valid_i;
            code_q  <= bus.error_code_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            ovf_cnt_q  <= '0;
        end else if (bus.clear_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (drop) begin
                overflow_q <= 1'b1;
                if (ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 1'b1;
            end
        end
    end

    // Log storage needs no reset: the read side masks it while empty
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_code[wr_ptr_q] <= bus.error_code_i;
            mem_ts[wr_ptr_q]   <= ts_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            timer_q <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (evt) begin
                        state_q <= StPending;
                        timer_q <= '0;
                    end
                end
                StPending: begin
                    if (bus.ack_i) begin
                        state_q <= StIdle;
                    end else if (timer_q == TmrW'(ESC_TIMEOUT - 1)) begin
                        state_q <= StEscalated;
                        fault_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StEscalated: begin
                    state_q <= StEscalated;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.rd_valid_o     = not_empty;
    assign bus.rd_code_o      = not_empty ? mem_code[rd_ptr_q] : '0;
    assign bus.rd_ts_o        = not_empty ? mem_ts[rd_ptr_q] : '0;
    assign bus.count_o        = count_q;
    assign bus.overflow_o     = overflow_q;
    assign bus.overflow_cnt_o = ovf_cnt_q;
    assign bus.esc_state_o    = state_q;
    assign bus.fault_o        = fault_q;
endmodule

// File: doc/error_event_logger.md
Name: error_event_logger

Overview:
- Downstream consumer of the safety island's aggregated error stream (error_valid/error_code pair, registered, level-held while the error persists).
- Deduplicates held errors into discrete events and timestamps each one.
- Stores events in a circular log for software readout.
- Runs an acknowledge-or-escalate FSM that raises a sticky fault_o when software does not acknowledge a logged error within ESC_TIMEOUT cycles.

Parameters:
- DEPTH, 16: log entries; power of 2, >=2.
- TS_W, 32: timestamp width.
- ESC_TIMEOUT, 1024: cycles from first unacknowledged event to escalation; >=1.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- error_valid_i  in  1  aggregated error valid (level)
- error_code_i  in  32  aggregated error code
- rd_valid_o  out  1  head log entry available
- rd_code_o  out  32  head entry error code
- rd_ts_o  out  TS_W  head entry timestamp
- rd_ready_i  in  1  pop head entry
- clear_i  in  1  flush log, clear overflow status
- ack_i  in  1  software acknowledge of pending error
- count_o  out  $clog2(DEPTH)+1  entries in log
- overflow_o  out  1  sticky: an event was dropped
- overflow_cnt_o  out  16  dropped-event count, saturating
- esc_state_o  out  2  FSM state (0 IDLE, 1 PENDING, 2 ESCALATED)
- fault_o  out  1  sticky escalation fault

Behaviour:
- Reset values: every output is 0 and the FSM is IDLE.
  - Outputs: rd_valid_o, rd_code_o, rd_ts_o, count_o, overflow_o, overflow_cnt_o, esc_state_o, fault_o.
  - Internal state: read/write pointers, ts counter, valid_q, code_q all 0.
- Timestamp:
  - Free-running TS_W counter, +1 every cycle from reset release.
  - Wraps from all-ones to 0 with no flag.
- Event detect:
  - event = error_valid_i && (!valid_q || error_code_i != code_q).
  - valid_q and code_q register error_valid_i and error_code_i every cycle.
  - A held error therefore logs once; a code change while valid logs again; a drop and re-assert logs again.
- Push:
  - On an event, {error_code_i, ts value in the same cycle} is written at the write pointer.
  - The entry becomes visible on rd_valid_o/rd_code_o/rd_ts_o the cycle after the event (1-cycle latency).
- Read side is show-ahead:
  - Head entry is driven whenever count_o>0.
  - Pop occurs when rd_valid_o && rd_ready_i.
  - When empty: rd_valid_o=0 and rd_code_o=rd_ts_o=0.
  - rd_ready_i while empty is ignored.
- Pointers: width $clog2(DEPTH) with natural wrap; count_o is maintained separately.
- Full, event, no pop in the same cycle:
  - The new event is dropped; the oldest entries are kept.
  - overflow_o is set.
  - overflow_cnt_o increments, saturating at 16'hFFFF.
- Full, event and pop in the same cycle: push is accepted and count_o stays at DEPTH.
- Empty, event and rd_ready_i in the same cycle: push only; no pop, because rd_valid_o was 0.
- clear_i:
  - Has priority over push and pop that cycle; a same-cycle event is discarded and not counted as overflow.
  - Resets pointers and count_o, overflow_o and overflow_cnt_o.
  - Does not touch the ts counter, valid_q/code_q, the FSM or fault_o.
- Escalation FSM:
  - IDLE -> PENDING on any event, whether accepted or dropped. The timer loads 0.
  - In PENDING:
    - Timer increments each cycle.
    - ack_i -> IDLE; ack_i has priority over timeout in the same cycle.
    - Timer reaching ESC_TIMEOUT-1 without ack_i -> ESCALATED.
    - Further events in PENDING do not restart the timer.
  - ESCALATED is terminal until reset. fault_o=1 from the first cycle in ESCALATED. ack_i and clear_i are ignored.
  - ack_i in IDLE is ignored.
  - Events in ESCALATED are still logged normally.
- Reset asserted mid-operation: everything returns to reset values asynchronously; log contents are lost.

Test Plan:
- Single event: error_valid_i=1, code 0xDEAD0001 held 10 cycles at ts=5 → exactly one entry {0xDEAD0001, ts=5}; rd_valid_o=1 next cycle; count_o=1.
- Dedup/re-log, with valid held: code 0xA then 0xB, then valid drops 1 cycle, then returns with 0xB → 3 entries in order A, B, B with increasing ts; popping all 3 with rd_ready_i=1 gives count_o=0 and rd_code_o=0.
- Overflow, DEPTH=16: 18 distinct events with no pops → count_o=16; entries are the first 16; overflow_o=1; overflow_cnt_o=2. A 19th event with a same-cycle pop is accepted and count_o stays 16. clear_i → count_o=0, overflow_o=0, overflow_cnt_o=0.
- Escalation, ESC_TIMEOUT=8: event with no ack → esc_state_o=1, then esc_state_o=2 and fault_o=1 exactly 8 cycles after entering PENDING. Subsequent ack_i and clear_i leave fault_o=1.
- Acknowledge: event, then ack_i on the cycle the timer equals 7 → IDLE, fault_o=0. A new event re-enters PENDING with the timer at 0.
- Reset mid-operation: 5 entries logged and FSM PENDING, assert rst_n_i asynchronously → all outputs 0 immediately and esc_state_o=0.
